sys_time_gen: RTL and testbench
===============================

SYS_TIME_GEN -- requirements
Module: sys_time_gen

Interface
REQ-001 The module SHALL have parameter SYNC0_CYCLE, default 20480, giving the CLK ticks between nominal SYNC0 pulses.
REQ-002 The module SHALL have parameter SYNC_TOL, default 4, giving the maximum absolute SYNC0 phase error in ticks that is corrected silently.
REQ-003 The module SHALL have port CLK, input, 1 bit: the single clock; all logic is on posedge CLK.
REQ-004 The module SHALL have port RST_N, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 The module SHALL have port SYNC0, input, 1 bit: the EtherCAT SYNC0 pulse, asynchronous to CLK.
REQ-006 The module SHALL have port SET, input, 1 bit: a single-cycle alignment request.
REQ-007 The module SHALL have port SYNC_BASE, input, 64 bits: the system time to be taken at the next SYNC0 edge; it is sampled only when SET=1.
REQ-008 The module SHALL have port SYS_TIME, output, 64 bits: the registered system time, consumed by the time-count divider stage.
REQ-009 The module SHALL have port LOCKED, output, 1 bit: high while SYS_TIME is aligned to SYNC0.
REQ-010 The module SHALL have port ERR_CNT, output, 8 bits: a saturating count of lock losses.

Function
REQ-011 SYNC0 SHALL pass a 2-FF synchronizer and a rising-edge detector; sync0_evt is a 1-cycle pulse, and total input latency is the package constant SYNC_LAT=3.
REQ-012 SYS_TIME SHALL increment by 1 every cycle and wrap from 2^64-1 to 0, except on the load cycles defined below.
REQ-013 The FSM SHALL have states UNSYNC, ARMED and LOCKED, and SHALL leave reset in UNSYNC.
REQ-014 SET=1 in any state SHALL latch SYNC_BASE into base_r, clear LOCKED and move to ARMED; SET has priority over a coincident sync0_evt, which is then ignored.
REQ-015 In ARMED, sync0_evt SHALL load SYS_TIME <= base_r+SYNC_LAT and exp_r <= base_r+SYNC0_CYCLE, set LOCKED and move to LOCKED.
REQ-016 In LOCKED, sync0_evt SHALL compute the signed 64-bit delta = (SYS_TIME+1)-(exp_r+SYNC_LAT), with modulo-2^64 wrap.
REQ-017 If |delta|<=SYNC_TOL, the module SHALL load SYS_TIME <= exp_r+SYNC_LAT and exp_r <= exp_r+SYNC0_CYCLE, and stay in LOCKED.
REQ-018 If |delta|>SYNC_TOL, SYS_TIME SHALL free-run, LOCKED SHALL go to 0, ERR_CNT SHALL increment, and the FSM SHALL move to UNSYNC.
REQ-019 In UNSYNC, sync0_evt SHALL have no effect; only SET leaves UNSYNC.
REQ-020 ERR_CNT SHALL saturate at 255 and be cleared only by reset.
REQ-021 LOCKED SHALL be registered and change on the same edge as the corresponding SYS_TIME load or drop.

Reset
REQ-022 While RST_N=0, SYS_TIME, base_r and exp_r SHALL be 0; LOCKED and ERR_CNT SHALL be 0; the synchronizer flops SHALL be 0; and the state SHALL be UNSYNC.
REQ-023 Deasserting reset mid-lock SHALL require a new SET, and SYNC0 held high across reset release SHALL NOT produce sync0_evt.

Configuration
REQ-024 With SYS_TIME_WDT_EN defined, a 16-bit watchdog counter SHALL count ticks since the last sync0_evt while in LOCKED.
REQ-025 With SYS_TIME_WDT_EN defined, the watchdog reaching 2*SYNC0_CYCLE SHALL trigger the same action as REQ-018.
REQ-026 With SYS_TIME_WDT_EN defined, the watchdog counter SHALL clear on every sync0_evt, on SET, and on any state change.
REQ-027 Without SYS_TIME_WDT_EN, no watchdog logic SHALL exist, and LOCKED SHALL persist without SYNC0 until an out-of-tolerance edge or SET.

Structure
REQ-028 Package sys_time_pkg SHALL hold the FSM state enum, SYNC_LAT, and the default SYNC0_CYCLE and SYNC_TOL values.
REQ-029 The synchronizer and edge detector SHALL be the sub-module sync0_edge_det, with ports CLK, RST_N, SYNC0 and EVT.

Verification
REQ-030 Bench SHALL check: reset release, no SET -> SYS_TIME reads 0,1,2,... per cycle, LOCKED=0, ERR_CNT=0.
REQ-031 Bench SHALL check: SET with SYNC_BASE=0x1000, then a SYNC0 pulse -> SYS_TIME=0x1003 on the load edge, LOCKED=1.
REQ-032 Bench SHALL check: locked, next SYNC0 arrives 20482 ticks after the previous one -> SYS_TIME snaps to 0x1000+20480+3, LOCKED stays 1, ERR_CNT=0.
REQ-033 Bench SHALL check: locked, next SYNC0 arrives 20470 ticks after the previous one -> no snap, LOCKED=0, ERR_CNT=1, and later SYNC0 pulses are ignored.
REQ-034 Bench SHALL check: SET coincident with sync0_evt while in ARMED -> state remains ARMED with the new base, and the next SYNC0 loads new base+3.
REQ-035 Bench SHALL check: with SYS_TIME_WDT_EN defined, locked with SYNC0 stopped -> LOCKED drops 40960 ticks after the last sync0_evt and ERR_CNT increments; with ERR_CNT preloaded by 300 losses it reads 255.

Source files
------------

// File: rtl/sys_time_pkg.sv
// Shared types and constants for the SYNC0-aligned system time generator.
package sys_time_pkg;

  typedef enum logic [1:0] {
    ST_UNSYNC = 2'd0,
    ST_ARMED  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // CLK edges from SYNC0 being sampled to the FSM acting on it
  localparam int unsigned SYNC_LAT        = 3;
  localparam int unsigned DEF_SYNC0_CYCLE = 20480;
  localparam int unsigned DEF_SYNC_TOL    = 4;

endpackage

// File: rtl/sync0_edge_det.sv
// Two-flop synchronizer plus registered rising-edge detector for SYNC0.
module sync0_edge_det (
  input  logic CLK,
  input  logic RST_N,
  input  logic SYNC0,
  output logic EVT
);

  localparam int STAGES = 2;

  logic              sync1, sync2, prev;
  logic [STAGES:0]   vld_pipe;

  // vld_pipe masks edges until prev holds a real sample, so a level held
  // high across reset release is not mistaken for an edge
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      prev     <= 1'b0;
      vld_pipe <= '0;
      EVT      <= 1'b0;
    end else begin
      sync1    <= SYNC0;
      sync2    <= sync1;
      prev     <= sync2;
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
      EVT      <= sync2 & ~prev & vld_pipe[STAGES];
    end
  end

endmodule

// File: rtl/sys_time_gen.sv
// 64-bit system time counter aligned to EtherCAT SYNC0 with phase tracking.
// Optional watchdog on missing SYNC0 when SYS_TIME_WDT_EN is defined.
module sys_time_gen
  import sys_time_pkg::*;
#(
  parameter int unsigned SYNC0_CYCLE = DEF_SYNC0_CYCLE,
  parameter int unsigned SYNC_TOL    = DEF_SYNC_TOL
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        SYNC0,
  input  logic        SET,
  input  logic [63:0] SYNC_BASE,
  output logic [63:0] SYS_TIME,
  output logic        LOCKED,
  output logic [7:0]  ERR_CNT
);

  state_t      state_q, state_d;
  logic [63:0] base_r, exp_r;
  logic [63:0] time_d, exp_d, base_d;
  logic        lock_d, err_inc;
  logic        sync0_evt;
  logic [63:0] delta;
  logic        in_tol;
  logic        wdt_fire;

  sync0_edge_det u_edge (
    .CLK   (CLK),
    .RST_N (RST_N),
    .SYNC0 (SYNC0),
    .EVT   (sync0_evt)
  );

  assign delta  = (SYS_TIME + 64'd1) - (exp_r + 64'(SYNC_LAT));
  assign in_tol = ($signed(delta) <= $signed(64'(SYNC_TOL))) &&
                  ($signed(delta) >= -$signed(64'(SYNC_TOL)));

`ifdef SYS_TIME_WDT_EN
  localparam int unsigned WDT_LIM = 2 * SYNC0_CYCLE;
  logic [15:0] wdt_q;

  // fires on the edge that completes WDT_LIM ticks since the last event
  assign wdt_fire = (wdt_q == 16'(WDT_LIM - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      wdt_q <= '0;
    else if (sync0_evt || SET || (state_d != state_q) || (state_q != ST_LOCKED))
      wdt_q <= '0;
    else
      wdt_q <= wdt_q + 16'd1;
  end
`else
  assign wdt_fire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    time_d  = SYS_TIME + 64'd1;
    exp_d   = exp_r;
    base_d  = base_r;
    lock_d  = LOCKED;
    err_inc = 1'b0;
    if (SET) begin
      base_d  = SYNC_BASE;
      lock_d  = 1'b0;
      state_d = ST_ARMED;
    end else begin
      case (state_q)
        ST_ARMED: if (sync0_evt) begin
          time_d  = base_r + 64'(SYNC_LAT);
          exp_d   = base_r + 64'(SYNC0_CYCLE);
          lock_d  = 1'b1;
          state_d = ST_LOCKED;
        end
        ST_LOCKED: begin
          if (sync0_evt && in_tol) begin
            time_d = exp_r + 64'(SYNC_LAT);
            exp_d  = exp_r + 64'(SYNC0_CYCLE);
          end else if (sync0_evt || wdt_fire) begin
            lock_d  = 1'b0;
            err_inc = 1'b1;
            state_d = ST_UNSYNC;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_UNSYNC;
      SYS_TIME <= '0;
      base_r   <= '0;
      exp_r    <= '0;
      LOCKED   <= 1'b0;
      ERR_CNT  <= '0;
    end else begin
      state_q  <= state_d;
      SYS_TIME <= time_d;
      base_r   <= base_d;
      exp_r    <= exp_d;
      LOCKED   <= lock_d;
      if (err_inc && (ERR_CNT != 8'hFF))
        ERR_CNT <= ERR_CNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_sys_time_gen.sv
// Directed bench for sys_time_gen: scheduled expectations in a cycle-indexed
// scoreboard, checked at each negedge. Honors SYS_TIME_WDT_EN if defined.
module tb_sys_time_gen;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        SYNC0;
  logic        SET;
  logic [63:0] SYNC_BASE;
  logic [63:0] SYS_TIME;
  logic        LOCKED;
  logic [7:0]  ERR_CNT;

  sys_time_gen dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .SYNC0     (SYNC0),
    .SET       (SET),
    .SYNC_BASE (SYNC_BASE),
    .SYS_TIME  (SYS_TIME),
    .LOCKED    (LOCKED),
    .ERR_CNT   (ERR_CNT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          c;
    string       tag;
    bit          chk_t;
    logic [63:0] t;
    logic        lk;
    logic [7:0]  ec;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   ntests = 0;
  int   nfail  = 0;

  function automatic void push(input int c, input string tag, input bit chk_t,
                               input logic [63:0] t, input logic lk, input logic [7:0] ec);
    exp_t e;
    int   i;
    e.c = c; e.tag = tag; e.chk_t = chk_t; e.t = t; e.lk = lk; e.ec = ec;
    i = sb.size();
    while (i > 0 && sb[i-1].c > c) i--;
    sb.insert(i, e);
  endfunction

  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].c <= cyc) begin
      cur = sb.pop_front();
      if (cur.c < cyc) begin
        ntests++;
        nfail++;
        $error("FAIL %s missed check at cycle %0d (now %0d)", cur.tag, cur.c, cyc);
      end else begin
        if (cur.chk_t) begin
          ntests++;
          assert (SYS_TIME === cur.t) else begin
            nfail++;
            $error("FAIL %s@%0d sys_time got %h exp %h", cur.tag, cyc, SYS_TIME, cur.t);
          end
        end
        ntests++;
        assert (LOCKED === cur.lk) else begin
          nfail++;
          $error("FAIL %s@%0d locked got %b exp %b", cur.tag, cyc, LOCKED, cur.lk);
        end
        ntests++;
        assert (ERR_CNT === cur.ec) else begin
          nfail++;
          $error("FAIL %s@%0d err_cnt got %0d exp %0d", cur.tag, cyc, ERR_CNT, cur.ec);
        end
      end
    end
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge CLK);
      #2;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  localparam logic [63:0] B1 = 64'h1000;
  localparam int B0 = 82000;
  localparam int E  = B0 + 3600;

  initial begin
    int ec0;
    int v;
    int b;
    logic [63:0] base;

    RST_N = 1'b0; SYNC0 = 1'b1; SET = 1'b0; SYNC_BASE = '0;

    // reset state, then free count with SYNC0 held high across release
    for (int c = 1; c <= 3; c++) push(c, "rst", 1, 64'd0, 1'b0, 8'd0);
    for (int c = 4; c <= 20; c++) push(c, "count", 1, 64'(c - 4), 1'b0, 8'd0);
    goto(4);  RST_N = 1'b1;
    goto(10); SET = 1'b1; SYNC_BASE = B1;
    goto(11); SET = 1'b0; SYNC_BASE = 64'hDEAD_BEEF;
    goto(16); SYNC0 = 1'b0;

    // first SYNC0 in ARMED: sampled at 22, loaded at 25
    push(24, "armed", 1, 64'd20, 1'b0, 8'd0);
    push(25, "load", 1, B1 + 3, 1'b1, 8'd0);
    push(26, "load+1", 1, B1 + 4, 1'b1, 8'd0);
    goto(21); SYNC0 = 1'b1;
    goto(23); SYNC0 = 1'b0;
    push(10025, "run", 1, B1 + 3 + 10000, 1'b1, 8'd0);

    // +2 tick late edge: snap
    push(20506, "pre_snap", 1, B1 + 3 + 20481, 1'b1, 8'd0);
    push(20507, "snap", 1, B1 + 20483, 1'b1, 8'd0);
    push(20508, "snap+1", 1, B1 + 20484, 1'b1, 8'd0);
    goto(20503); SYNC0 = 1'b1;
    goto(20505); SYNC0 = 1'b0;

    // -10 tick early edge: lock loss
    push(40976, "pre_loss", 1, B1 + 40952, 1'b1, 8'd0);
    push(40977, "loss", 1, B1 + 40953, 1'b0, 8'd1);
    goto(40973); SYNC0 = 1'b1;
    goto(40975); SYNC0 = 1'b0;

    // SYNC0 ignored in UNSYNC
    push(40994, "unsync_ign", 1, B1 + 40953 + 17, 1'b0, 8'd1);
    goto(40989); SYNC0 = 1'b1;
    goto(40991); SYNC0 = 1'b0;

    // SET coincident with event in ARMED
    goto(41000); SET = 1'b1; SYNC_BASE = 64'h2000;
    goto(41001); SET = 1'b0;
    push(41013, "set_prio", 1, B1 + 40953 + 36, 1'b0, 8'd1);
    push(41014, "set_prio+1", 1, B1 + 40953 + 37, 1'b0, 8'd1);
    push(41032, "rearm", 1, B1 + 40953 + 55, 1'b0, 8'd1);
    push(41033, "reload", 1, 64'h3003, 1'b1, 8'd1);
    goto(41009); SYNC0 = 1'b1;
    goto(41011); SYNC0 = 1'b0;
    goto(41012); SET = 1'b1; SYNC_BASE = 64'h3000;
    goto(41013); SET = 1'b0;
    goto(41029); SYNC0 = 1'b1;
    goto(41031); SYNC0 = 1'b0;

    // SYNC0 stops while locked
    push(81992, "wdt_pre", 1, 64'h3003 + 40959, 1'b1, 8'd1);
`ifdef SYS_TIME_WDT_EN
    push(81993, "wdt_drop", 1, 64'h3003 + 40960, 1'b0, 8'd2);
    ec0 = 2;
`else
    push(81993, "no_wdt", 1, 64'h3003 + 40960, 1'b1, 8'd1);
    ec0 = 1;
`endif

    // repeated lock/loss cycles to saturate ERR_CNT
    for (int i = 0; i < 300; i++) begin
      b    = B0 + 12 * i;
      base = 64'h5000 + 64'(i * 16);
      v = ec0 + i;     if (v > 255) v = 255;
      push(b + 5, "sat_lock", 1, base + 3, 1'b1, 8'(v));
      v = ec0 + i + 1; if (v > 255) v = 255;
      push(b + 10, "sat_loss", 0, 64'd0, 1'b0, 8'(v));
      goto(b);     SET = 1'b1; SYNC_BASE = base;
      goto(b + 1); SET = 1'b0; SYNC0 = 1'b1;
      goto(b + 3); SYNC0 = 1'b0;
      goto(b + 6); SYNC0 = 1'b1;
      goto(b + 8); SYNC0 = 1'b0;
    end

    // reset asserted mid-lock; afterwards SYNC0 alone does nothing
    push(E + 5, "pre_rst_lock", 1, 64'h7003, 1'b1, 8'd255);
    push(E + 8, "rst_mid", 1, 64'd0, 1'b0, 8'd0);
    push(E + 9, "rst_mid2", 1, 64'd0, 1'b0, 8'd0);
    for (int c = E + 10; c <= E + 13; c++) push(c, "post_rst", 1, 64'(c - (E + 10)), 1'b0, 8'd0);
    push(E + 19, "post_rst_ign", 1, 64'd9, 1'b0, 8'd0);
    goto(E);      SET = 1'b1; SYNC_BASE = 64'h7000;
    goto(E + 1);  SET = 1'b0; SYNC0 = 1'b1;
    goto(E + 3);  SYNC0 = 1'b0;
    goto(E + 8);  RST_N = 1'b0;
    goto(E + 10); RST_N = 1'b1;
    goto(E + 14); SYNC0 = 1'b1;
    goto(E + 16); SYNC0 = 1'b0;
    goto(E + 25);

    ntests++;
    assert (sb.size() == 0) else begin
      nfail++;
      $error("FAIL drain scoreboard has %0d pending, exp 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
